multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Multicycle MIPS control unit; replaces the single-cycle opcode decoder.
- A Moore FSM sequences each instruction over 3-5 cycles and stalls on a memory ready handshake.
- Counts retired instructions and flags illegal opcodes.
- Sits between the instruction register's opcode field and the shared-ALU/shared-memory datapath.

Parameters:
- CNT_W, 32: width of the retired-instruction counter; wraps modulo 2^CNT_W.
- ENABLE_IMM, 1: 1 = ADDI/ANDI/ORI/SLTI supported; 0 = those opcodes are illegal.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high.
- opcode  in  6  IR[31:26]; stable from DECODE until the instruction ends.
- mem_ready  in  1  memory completes the current read/write this cycle.
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  load IR.
- pc_write  out  1  unconditional PC write.
- branch  out  1  conditional PC write (ANDed with Zero in the datapath).
- pc_src  out  2  00 = ALUResult, 01 = ALUOut, 10 = jump target.
- alu_src_a  out  1  0 = PC, 1 = register A.
- alu_src_b  out  2  00 = register B, 01 = constant 4, 10 = SignImm, 11 = SignImm<<2.
- alu_op  out  2  00 = add, 01 = sub, 10 = funct field, 11 = immediate op (decoded by ALU control).
- reg_dst  out  1  0 = rt, 1 = rd.
- mem_to_reg  out  1  0 = ALUOut, 1 = memory data register.
- reg_write  out  1  register file write enable.
- instr_done  out  1  1-cycle pulse on the final cycle of a retiring instruction.
- illegal_op  out  1  1-cycle pulse in DECODE when the opcode is unsupported.
- retired_cnt  out  CNT_W  retired-instruction count.

Behaviour:
- Clock and reset: one clock `clk`; reset is synchronous and active-high on `reset`.
- Reset: state <= FETCH, retired_cnt <= 0. While reset=1, all control outputs are forced to 0.
- Output style: outputs are combinational from state, plus mem_ready and opcode where noted. Any signal not listed for a state is 0; the block never drives x.
- FETCH: mem_read=1, alu_src_b=01, alu_op=00, pc_src=00.
  - ir_write=1 and pc_write=1 only while mem_ready=1.
  - Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE: alu_src_b=11, alu_op=00 (branch target into ALUOut). Next state by opcode:
  - 000000 -> EXEC
  - 100011 or 101011 -> MEMADR
  - 000100 -> BRANCH
  - 000010 -> JUMP
  - 001000, 001100, 001101, 001010 -> IMMEXEC if ENABLE_IMM=1
  - any other opcode -> FETCH with illegal_op=1; the instruction is not counted.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Next: LW -> MEMRD, SW -> MEMWR.
- MEMRD: iord=1, mem_read=1; hold until mem_ready=1, then go to MEMWB.
- MEMWB: mem_to_reg=1, reg_write=1, instr_done=1; next FETCH.
- MEMWR: iord=1, mem_write=1; hold until mem_ready=1. instr_done=1 in the mem_ready cycle, then FETCH.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10; next ALUWB.
- ALUWB: reg_dst=1, reg_write=1, instr_done=1; next FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, branch=1, pc_src=01, instr_done=1; next FETCH.
- IMMEXEC: alu_src_a=1, alu_src_b=10, alu_op=11; next IMMWB.
- IMMWB: reg_write=1, instr_done=1; next FETCH.
- JUMP: pc_src=10, pc_write=1, instr_done=1; next FETCH.
- Latency with mem_ready held 1: R-type/immediate 4 cycles, LW 5, SW 4, BEQ 3, J 3, illegal 2. Each low mem_ready cycle adds one cycle in a wait state.
- retired_cnt: increments on every edge where instr_done=1 and reset=0; wraps all-ones -> 0 with no flag.
- Reset mid-instruction: reset takes priority over everything, including a same-cycle mem_ready or instr_done. The counter is not incremented and the FSM restarts in FETCH.
- Unreachable state encodings go to FETCH with all outputs 0.

Decomposition:
- Package multicycle_ctrl_pkg holds:
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI;
  - the state enum;
  - encodings for alu_op, alu_src_b and pc_src.
- No sub-module; the DECODE dispatch is a package function.

Test Plan:
- R-type (000000), mem_ready=1 -> states FETCH, DECODE, EXEC, ALUWB. reg_dst=1 and reg_write=1 in cycle 4, instr_done once, retired_cnt 0->1.
- LW (100011), mem_ready=0 for 3 cycles in MEMRD -> MEMRD holds 4 cycles with iord=1, mem_read=1. MEMWB then shows mem_to_reg=1, reg_write=1; 8 cycles total.
- SW (101011), mem_ready=0 for 2 cycles in FETCH -> ir_write stays 0 until the ready cycle. mem_write=1 in MEMWR; instr_done in the same cycle as mem_ready.
- Opcode 111111, and ADDI with ENABLE_IMM=0 -> illegal_op=1 in cycle 2, FETCH in cycle 3, retired_cnt unchanged, no reg_write or mem_write.
- Reset asserted in MEMRD with mem_ready=1 -> next state FETCH, all outputs 0 during reset, retired_cnt=0.
- CNT_W=4: 17 back-to-back J (000010) instructions -> retired_cnt wraps 15->0 and ends at 1; pc_write=1 with pc_src=10 each JUMP.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control unit: opcodes, state
// encodings, datapath select encodings and the DECODE dispatch function.
package multicycle_ctrl_pkg;

  // Opcode field values (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  // FSM state encodings; 12..15 are unused and recover to FETCH.
  typedef logic [3:0] state_t;
  localparam state_t S_FETCH   = 4'd0;
  localparam state_t S_DECODE  = 4'd1;
  localparam state_t S_MEMADR  = 4'd2;
  localparam state_t S_MEMRD   = 4'd3;
  localparam state_t S_MEMWB   = 4'd4;
  localparam state_t S_MEMWR   = 4'd5;
  localparam state_t S_EXEC    = 4'd6;
  localparam state_t S_ALUWB   = 4'd7;
  localparam state_t S_BRANCH  = 4'd8;
  localparam state_t S_IMMEXEC = 4'd9;
  localparam state_t S_IMMWB   = 4'd10;
  localparam state_t S_JUMP    = 4'd11;

  // alu_op encodings
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_IMM   = 2'b11;

  // alu_src_b encodings
  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMMSH  = 2'b11;

  // pc_src encodings
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // State following DECODE for a given opcode. Returning S_FETCH means the
  // opcode is not supported and the instruction is dropped.
  function automatic state_t decode_dispatch(input logic [5:0] op,
                                             input logic imm_en);
    state_t nxt;
    nxt = S_FETCH;
    case (op)
      OP_RTYPE: nxt = S_EXEC;
      OP_LW,
      OP_SW:    nxt = S_MEMADR;
      OP_BEQ:   nxt = S_BRANCH;
      OP_J:     nxt = S_JUMP;
      OP_ADDI,
      OP_ANDI,
      OP_ORI,
      OP_SLTI:  nxt = imm_en ? S_IMMEXEC : S_FETCH;
      default:  nxt = S_FETCH;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/multicycle_control.sv
// Multicycle MIPS control unit. Moore FSM sequencing each instruction over
// 3-5 cycles, stalling in FETCH/MEMRD/MEMWR until mem_ready, counting
// retired instructions and flagging unsupported opcodes in DECODE.
//
// Handshake: a memory access is requested by holding mem_read/mem_write
// high; the access completes in the cycle mem_ready=1 is seen, and the FSM
// leaves the wait state on that edge. Requests stay high while stalled.
//
// state_dbg exposes the raw FSM state (not forced by reset) for observation.
module multicycle_control
  import multicycle_ctrl_pkg::*;
#(
  parameter int CNT_W      = 32,
  parameter bit ENABLE_IMM = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             pc_write,
  output logic             branch,
  output logic [1:0]       pc_src,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             instr_done,
  output logic             illegal_op,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [3:0]       state_dbg
);

  state_t state;
  state_t next_state;
  state_t dispatch;

  assign dispatch  = decode_dispatch(opcode, ENABLE_IMM);
  assign state_dbg = state;

  // Next-state selection; stalls hold the wait state until mem_ready.
  always_comb begin
    next_state = S_FETCH;
    case (state)
      S_FETCH:   next_state = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE:  next_state = dispatch;
      S_MEMADR:  next_state = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   next_state = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:   next_state = S_FETCH;
      S_MEMWR:   next_state = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:    next_state = S_ALUWB;
      S_ALUWB:   next_state = S_FETCH;
      S_BRANCH:  next_state = S_FETCH;
      S_IMMEXEC: next_state = S_IMMWB;
      S_IMMWB:   next_state = S_FETCH;
      S_JUMP:    next_state = S_FETCH;
      default:   next_state = S_FETCH;
    endcase
  end

  // Control outputs decoded from state; everything is held at 0 during reset.
  always_comb begin
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    branch     = 1'b0;
    pc_src     = PCSRC_ALU;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REG;
    alu_op     = ALUOP_ADD;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    instr_done = 1'b0;
    illegal_op = 1'b0;
    if (!reset) begin
      case (state)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = SRCB_FOUR;
          alu_op    = ALUOP_ADD;
          pc_src    = PCSRC_ALU;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE: begin
          alu_src_b  = SRCB_IMMSH;
          alu_op     = ALUOP_ADD;
          illegal_op = (dispatch == S_FETCH);
        end
        S_MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          alu_op    = ALUOP_ADD;
        end
        S_MEMRD: begin
          iord     = 1'b1;
          mem_read = 1'b1;
        end
        S_MEMWB: begin
          mem_to_reg = 1'b1;
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        S_MEMWR: begin
          iord       = 1'b1;
          mem_write  = 1'b1;
          instr_done = mem_ready;
        end
        S_EXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_REG;
          alu_op    = ALUOP_FUNCT;
        end
        S_ALUWB: begin
          reg_dst    = 1'b1;
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a  = 1'b1;
          alu_src_b  = SRCB_REG;
          alu_op     = ALUOP_SUB;
          branch     = 1'b1;
          pc_src     = PCSRC_ALUOUT;
          instr_done = 1'b1;
        end
        S_IMMEXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          alu_op    = ALUOP_IMM;
        end
        S_IMMWB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        S_JUMP: begin
          pc_src     = PCSRC_JUMP;
          pc_write   = 1'b1;
          instr_done = 1'b1;
        end
        default: begin
          // unreachable encodings: all outputs stay 0
        end
      endcase
    end
  end

  // State register and retired counter; reset wins over any same-cycle
  // completion, so an instruction cut short by reset is never counted.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_FETCH;
      retired_cnt <= '0;
    end else begin
      state <= next_state;
      if (instr_done) begin
        retired_cnt <= retired_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control. Two instances share the inputs:
// dut_a (CNT_W=32, ENABLE_IMM=1) and dut_b (CNT_W=4, ENABLE_IMM=0); sel
// chooses which one the monitor checks. Each driven cycle pushes the
// hand-computed expected {state, controls, count}; the monitor pops and
// compares on the falling edge.
module tb_multicycle_control;
  import multicycle_ctrl_pkg::*;

  localparam int W = 54;

  // Expected control vectors, bit order:
  // {iord, mem_read, mem_write, ir_write, pc_write, branch, pc_src[1:0],
  //  alu_src_a, alu_src_b[1:0], alu_op[1:0], reg_dst, mem_to_reg,
  //  reg_write, instr_done, illegal_op}
  localparam logic [17:0] C_ZERO     = 18'b0_0_0_0_0_0_00_0_00_00_0_0_0_0_0;
  localparam logic [17:0] C_FETCH_W  = 18'b0_1_0_0_0_0_00_0_01_00_0_0_0_0_0;
  localparam logic [17:0] C_FETCH_R  = 18'b0_1_0_1_1_0_00_0_01_00_0_0_0_0_0;
  localparam logic [17:0] C_DECODE   = 18'b0_0_0_0_0_0_00_0_11_00_0_0_0_0_0;
  localparam logic [17:0] C_DEC_ILL  = 18'b0_0_0_0_0_0_00_0_11_00_0_0_0_0_1;
  localparam logic [17:0] C_MEMADR   = 18'b0_0_0_0_0_0_00_1_10_00_0_0_0_0_0;
  localparam logic [17:0] C_MEMRD    = 18'b1_1_0_0_0_0_00_0_00_00_0_0_0_0_0;
  localparam logic [17:0] C_MEMWB    = 18'b0_0_0_0_0_0_00_0_00_00_0_1_1_1_0;
  localparam logic [17:0] C_MEMWR_W  = 18'b1_0_1_0_0_0_00_0_00_00_0_0_0_0_0;
  localparam logic [17:0] C_MEMWR_R  = 18'b1_0_1_0_0_0_00_0_00_00_0_0_0_1_0;
  localparam logic [17:0] C_EXEC     = 18'b0_0_0_0_0_0_00_1_00_10_0_0_0_0_0;
  localparam logic [17:0] C_ALUWB    = 18'b0_0_0_0_0_0_00_0_00_00_1_0_1_1_0;
  localparam logic [17:0] C_BRANCH   = 18'b0_0_0_0_0_1_01_1_00_01_0_0_0_1_0;
  localparam logic [17:0] C_IMMEXEC  = 18'b0_0_0_0_0_0_00_1_10_11_0_0_0_0_0;
  localparam logic [17:0] C_IMMWB    = 18'b0_0_0_0_0_0_00_0_00_00_0_0_1_1_0;
  localparam logic [17:0] C_JUMP     = 18'b0_0_0_0_1_0_10_0_00_00_0_0_0_1_0;

  // Clock/reset and shared inputs
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic       mem_ready = 1'b0;
  logic       sel = 1'b0;

  always #5 clk = ~clk;

  // dut_a outputs
  logic        a_iord, a_mem_read, a_mem_write, a_ir_write, a_pc_write, a_branch;
  logic [1:0]  a_pc_src, a_alu_src_b, a_alu_op;
  logic        a_alu_src_a, a_reg_dst, a_mem_to_reg, a_reg_write, a_instr_done, a_illegal_op;
  logic [31:0] a_cnt;
  logic [3:0]  a_state;

  // dut_b outputs
  logic        b_iord, b_mem_read, b_mem_write, b_ir_write, b_pc_write, b_branch;
  logic [1:0]  b_pc_src, b_alu_src_b, b_alu_op;
  logic        b_alu_src_a, b_reg_dst, b_mem_to_reg, b_reg_write, b_instr_done, b_illegal_op;
  logic [3:0]  b_cnt;
  logic [3:0]  b_state;

  multicycle_control #(.CNT_W(32), .ENABLE_IMM(1'b1)) dut_a (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .iord(a_iord), .mem_read(a_mem_read), .mem_write(a_mem_write),
    .ir_write(a_ir_write), .pc_write(a_pc_write), .branch(a_branch),
    .pc_src(a_pc_src), .alu_src_a(a_alu_src_a), .alu_src_b(a_alu_src_b),
    .alu_op(a_alu_op), .reg_dst(a_reg_dst), .mem_to_reg(a_mem_to_reg),
    .reg_write(a_reg_write), .instr_done(a_instr_done),
    .illegal_op(a_illegal_op), .retired_cnt(a_cnt), .state_dbg(a_state)
  );

  multicycle_control #(.CNT_W(4), .ENABLE_IMM(1'b0)) dut_b (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .iord(b_iord), .mem_read(b_mem_read), .mem_write(b_mem_write),
    .ir_write(b_ir_write), .pc_write(b_pc_write), .branch(b_branch),
    .pc_src(b_pc_src), .alu_src_a(b_alu_src_a), .alu_src_b(b_alu_src_b),
    .alu_op(b_alu_op), .reg_dst(b_reg_dst), .mem_to_reg(b_mem_to_reg),
    .reg_write(b_reg_write), .instr_done(b_instr_done),
    .illegal_op(b_illegal_op), .retired_cnt(b_cnt), .state_dbg(b_state)
  );

  logic [17:0] a_ctrl, b_ctrl;
  assign a_ctrl = {a_iord, a_mem_read, a_mem_write, a_ir_write, a_pc_write, a_branch,
                   a_pc_src, a_alu_src_a, a_alu_src_b, a_alu_op, a_reg_dst,
                   a_mem_to_reg, a_reg_write, a_instr_done, a_illegal_op};
  assign b_ctrl = {b_iord, b_mem_read, b_mem_write, b_ir_write, b_pc_write, b_branch,
                   b_pc_src, b_alu_src_a, b_alu_src_b, b_alu_op, b_reg_dst,
                   b_mem_to_reg, b_reg_write, b_instr_done, b_illegal_op};

  // Scoreboard
  logic [W-1:0] exp_q[$];
  logic [31:0]  exp_cnt = 32'd0;
  logic [31:0]  cnt_mask = 32'hFFFF_FFFF;
  int           n_cmp = 0;
  int           n_bad = 0;
  int           cyc = 0;

  // Monitor: pop one expectation per checked cycle and compare
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      logic [3:0]   g_state;
      logic [17:0]  g_ctrl;
      logic [31:0]  g_cnt;
      e       = exp_q.pop_front();
      g_state = sel ? b_state : a_state;
      g_ctrl  = sel ? b_ctrl  : a_ctrl;
      g_cnt   = sel ? {28'd0, b_cnt} : a_cnt;
      cyc++;
      n_cmp++;
      if (g_state !== e[53:50]) begin
        n_bad++;
        $display("FAIL state cyc=%0d dut=%s got=%0d exp=%0d", cyc, sel ? "b" : "a", g_state, e[53:50]);
      end
      n_cmp++;
      if (g_ctrl !== e[49:32]) begin
        n_bad++;
        $display("FAIL ctrl cyc=%0d dut=%s got=%b exp=%b", cyc, sel ? "b" : "a", g_ctrl, e[49:32]);
      end
      n_cmp++;
      if (g_cnt !== e[31:0]) begin
        n_bad++;
        $display("FAIL retired_cnt cyc=%0d dut=%s got=%0d exp=%0d", cyc, sel ? "b" : "a", g_cnt, e[31:0]);
      end
    end
  end

  // Driver: apply one cycle of inputs and queue the expected response
  task automatic step(input logic [5:0] op, input logic rdy, input logic rst,
                      input logic [3:0] st, input logic [17:0] ctrl);
    opcode    = op;
    mem_ready = rdy;
    reset     = rst;
    exp_q.push_back({st, ctrl, exp_cnt});
    if (rst) exp_cnt = 32'd0;
    else if (ctrl[1]) exp_cnt = (exp_cnt + 32'd1) & cnt_mask;
    @(posedge clk);
    #1;
  endtask

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    @(posedge clk);
    #1;
    // reset state: FETCH, count 0, outputs forced 0
    step(6'h00, 1'b1, 1'b1, S_FETCH, C_ZERO);

    // R-type, mem_ready held 1: 4 cycles
    step(OP_RTYPE, 1'b1, 1'b0, S_FETCH,  C_FETCH_R);
    step(OP_RTYPE, 1'b1, 1'b0, S_DECODE, C_DECODE);
    step(OP_RTYPE, 1'b1, 1'b0, S_EXEC,   C_EXEC);
    step(OP_RTYPE, 1'b1, 1'b0, S_ALUWB,  C_ALUWB);

    // LW with 3 stall cycles in MEMRD: 8 cycles
    step(OP_LW, 1'b1, 1'b0, S_FETCH,  C_FETCH_R);
    step(OP_LW, 1'b1, 1'b0, S_DECODE, C_DECODE);
    step(OP_LW, 1'b1, 1'b0, S_MEMADR, C_MEMADR);
    step(OP_LW, 1'b0, 1'b0, S_MEMRD,  C_MEMRD);
    step(OP_LW, 1'b0, 1'b0, S_MEMRD,  C_MEMRD);
    step(OP_LW, 1'b0, 1'b0, S_MEMRD,  C_MEMRD);
    step(OP_LW, 1'b1, 1'b0, S_MEMRD,  C_MEMRD);
    step(OP_LW, 1'b1, 1'b0, S_MEMWB,  C_MEMWB);

    // SW with 2 stall cycles in FETCH and one in MEMWR
    step(OP_SW, 1'b0, 1'b0, S_FETCH,  C_FETCH_W);
    step(OP_SW, 1'b0, 1'b0, S_FETCH,  C_FETCH_W);
    step(OP_SW, 1'b1, 1'b0, S_FETCH,  C_FETCH_R);
    step(OP_SW, 1'b1, 1'b0, S_DECODE, C_DECODE);
    step(OP_SW, 1'b1, 1'b0, S_MEMADR, C_MEMADR);
    step(OP_SW, 1'b0, 1'b0, S_MEMWR,  C_MEMWR_W);
    step(OP_SW, 1'b1, 1'b0, S_MEMWR,  C_MEMWR_R);

    // BEQ: 3 cycles
    step(OP_BEQ, 1'b1, 1'b0, S_FETCH,  C_FETCH_R);
    step(OP_BEQ, 1'b1, 1'b0, S_DECODE, C_DECODE);
    step(OP_BEQ, 1'b1, 1'b0, S_BRANCH, C_BRANCH);

    // J: 3 cycles
    step(OP_J, 1'b1, 1'b0, S_FETCH,  C_FETCH_R);
    step(OP_J, 1'b1, 1'b0, S_DECODE, C_DECODE);
    step(OP_J, 1'b1, 1'b0, S_JUMP,   C_JUMP);

    // ADDI with immediates enabled: 4 cycles
    step(OP_ADDI, 1'b1, 1'b0, S_FETCH,   C_FETCH_R);
    step(OP_ADDI, 1'b1, 1'b0, S_DECODE,  C_DECODE);
    step(OP_ADDI, 1'b1, 1'b0, S_IMMEXEC, C_IMMEXEC);
    step(OP_ADDI, 1'b1, 1'b0, S_IMMWB,   C_IMMWB);

    // ORI and SLTI take the same path
    step(OP_ORI,  1'b1, 1'b0, S_FETCH,   C_FETCH_R);
    step(OP_ORI,  1'b1, 1'b0, S_DECODE,  C_DECODE);
    step(OP_ORI,  1'b1, 1'b0, S_IMMEXEC, C_IMMEXEC);
    step(OP_ORI,  1'b1, 1'b0, S_IMMWB,   C_IMMWB);

    // Illegal 111111: flagged in DECODE, not counted, back to FETCH
    step(6'b111111, 1'b1, 1'b0, S_FETCH,  C_FETCH_R);
    step(6'b111111, 1'b1, 1'b0, S_DECODE, C_DEC_ILL);

    // Reset in MEMRD with mem_ready=1: outputs 0, then FETCH with count 0
    step(OP_LW, 1'b1, 1'b0, S_FETCH,  C_FETCH_R);
    step(OP_LW, 1'b1, 1'b0, S_DECODE, C_DECODE);
    step(OP_LW, 1'b1, 1'b0, S_MEMADR, C_MEMADR);
    step(OP_LW, 1'b1, 1'b1, S_MEMRD,  C_ZERO);
    step(OP_LW, 1'b0, 1'b0, S_FETCH,  C_FETCH_W);

    // Switch to dut_b (CNT_W=4, ENABLE_IMM=0); align it with an unchecked reset cycle
    sel      = 1'b1;
    cnt_mask = 32'h0000_000F;
    reset    = 1'b1;
    opcode   = 6'd0;
    @(posedge clk);
    #1;
    exp_cnt = 32'd0;
    step(6'h00, 1'b0, 1'b1, S_FETCH, C_ZERO);

    // ADDI is illegal with immediates disabled
    step(OP_ADDI, 1'b1, 1'b0, S_FETCH,  C_FETCH_R);
    step(OP_ADDI, 1'b1, 1'b0, S_DECODE, C_DEC_ILL);
    step(6'b111111, 1'b1, 1'b0, S_FETCH,  C_FETCH_R);
    step(6'b111111, 1'b1, 1'b0, S_DECODE, C_DEC_ILL);

    // 17 back-to-back jumps: counter wraps 15 -> 0 and ends at 1
    for (int i = 0; i < 17; i++) begin
      step(OP_J, 1'b1, 1'b0, S_FETCH,  C_FETCH_R);
      step(OP_J, 1'b1, 1'b0, S_DECODE, C_DECODE);
      step(OP_J, 1'b1, 1'b0, S_JUMP,   C_JUMP);
    end
    step(OP_J, 1'b0, 1'b0, S_FETCH, C_FETCH_W);

    // Drain: the monitor must have consumed every expectation
    @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain got=%0d pending exp=0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
